fractal_sync_mp_admit: RTL and testbench
========================================

FRACTAL_SYNC_MP_ADMIT -- requirements
Module: fractal_sync_mp_admit

Interface
REQ-001 Parameter N_PORTS, default 2: number of request ports; SHALL be > 0, otherwise elaboration fails fatally.
REQ-002 Parameter FIFO_DEPTH, default 1: depth of the downstream multi-port FIFO; SHALL be > 0, otherwise elaboration fails fatally.
REQ-003 Parameter fifo_t, default logic: element type.
REQ-004 Localparam AVAIL_W SHALL equal $clog2(FIFO_DEPTH)+1.
REQ-005 clk_i  input  1  single clock; all state on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 valid_i[N_PORTS]  input  1 each  request valid per port.
REQ-008 element_i[N_PORTS]  input  fifo_t each  request payload per port.
REQ-009 ready_o[N_PORTS]  output  1 each  request accepted this cycle.
REQ-010 avail_i  input  AVAIL_W  free slots reported by the downstream FIFO.
REQ-011 push_o[N_PORTS]  output  1 each  registered push to the downstream FIFO, per port.
REQ-012 element_o[N_PORTS]  output  fifo_t each  registered payload paired with push_o.
REQ-013 stall_o  output  1  registered; high when, in the previous cycle, at least one valid_i was high and not accepted.

Function
REQ-014 Transfer on port i SHALL occur when valid_i[i] & ready_o[i] are both high in the same cycle.
REQ-015 ready_o[i] SHALL be high only when valid_i[i] is high; ready_o is combinational from valid_i, avail_i and internal state.
REQ-016 Budget SHALL be computed as avail_i minus popcount(push_o), saturating at 0, in AVAIL_W+1-bit arithmetic.
REQ-017 The block SHALL NOT accept more requests per cycle than the budget, so the downstream FIFO never overflows.
REQ-018 Grant order SHALL be a scan of ports from start index S, wrapping modulo N_PORTS, granting valid ports until the budget is exhausted.
REQ-019 S is defined per build in REQ-030/REQ-031.
REQ-020 Each accepted request on port i SHALL produce push_o[i]=1 and element_o[i]=element_i[i] on the next cycle: latency is exactly 1 cycle.
REQ-021 Ports not accepted SHALL drive push_o[i]=0 on the next cycle; element_o[i] holds its previous value.
REQ-022 Order within one cycle SHALL follow port index (lowest index first), as stored by the downstream FIFO, irrespective of grant order.
REQ-023 Budget 0: all ready_o low; push_o all low next cycle; stall_o high next cycle if any valid_i was high.
REQ-024 Budget >= N_PORTS: every valid port is accepted in the same cycle.
REQ-025 No valid_i high: nothing is granted, and no state changes except push_o/stall_o going low.
REQ-026 Upstream SHALL keep valid_i[i] and element_i[i] stable until accepted; the block does not latch unaccepted requests.

Reset
REQ-027 While rst_ni is low: push_o all 0, element_o all '0, stall_o 0, rr_ptr 0.
REQ-028 ready_o SHALL be 0 during reset.
REQ-029 Reset asserted mid-operation SHALL drop any registered, not-yet-pushed request; pending pushes are not replayed after reset.

Configuration
REQ-030 With macro FRACTAL_SYNC_MP_ADMIT_RR_EN defined: a register rr_ptr (width $clog2(N_PORTS), 1 bit minimum) SHALL provide S.
REQ-031 With FRACTAL_SYNC_MP_ADMIT_RR_EN defined: after any cycle with at least one grant, rr_ptr SHALL become (last granted index + 1) mod N_PORTS; it is unchanged when there is no grant.
REQ-032 Without FRACTAL_SYNC_MP_ADMIT_RR_EN: S SHALL be fixed at 0 (fixed priority, lowest index first), and rr_ptr SHALL not exist.

Verification
REQ-033 N_PORTS=4, avail_i=8, all valid, elements 0xA..0xD -> all ready_o high; next cycle push_o=4'b1111, element_o=A,B,C,D.
REQ-034 N_PORTS=4, avail_i=2, all valid, RR enabled, rr_ptr=0 -> cycle 1 grants ports 0,1, rr_ptr=2; cycle 2 (avail_i=2, push_o count 2) budget 0, no grant, stall_o high next cycle; cycle 3 (avail_i=2) grants ports 2,3, rr_ptr=0.
REQ-035 Same stimulus with RR disabled -> ports 0,1 are granted each time budget allows; ports 2,3 starve while ports 0,1 stay valid.
REQ-036 FIFO_DEPTH=1, N_PORTS=2, both valid every cycle, avail_i fed from a real FIFO -> at most one push per two cycles; FIFO overflow never asserts.
REQ-037 Reset asserted the cycle after a grant -> push_o=0 immediately, stall_o=0, rr_ptr=0; the granted element is never pushed.
REQ-038 avail_i=1 with push_o count 2 (avail_i stale) -> budget saturates at 0, all ready_o low.

Source files
------------

// File: rtl/fractal_sync_mp_admit.sv
// fractal_sync_mp_admit
//   Admission stage in front of a multi-port FIFO. Each cycle it grants at
//   most as many valid request ports as the FIFO has room for. The budget is
//   the FIFO's reported free slots minus the pushes already in flight.
//   Accepted requests are registered and pushed one cycle later.
//
// Build option:
//   FRACTAL_SYNC_MP_ADMIT_RR_EN - round-robin grant start (rr_ptr_q).
//                                 If not defined, fixed priority from port 0.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   valid_i        per-port request valid
//   element_i      per-port request payload
//   ready_o        per-port accept (combinational)
//   avail_i        free slots reported by the downstream FIFO
//   push_o         per-port registered push to the FIFO
//   element_o      per-port registered payload paired with push_o
//   stall_o        registered: some valid request was refused last cycle

// Per-port output register: push flag plus payload, which holds when idle.
module fractal_sync_mp_admit_lane #(
  parameter type fifo_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  acc_i,
  input  fifo_t elem_i,
  output logic  push_o,
  output fifo_t elem_o
);
  logic  push_q;
  fifo_t elem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_q <= 1'b0;
      elem_q <= '0;
    end else begin
      push_q <= acc_i;
      if (acc_i) elem_q <= elem_i;
    end
  end

  assign push_o = push_q;
  assign elem_o = elem_q;
endmodule

module fractal_sync_mp_admit #(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned FIFO_DEPTH = 1,
  parameter type         fifo_t     = logic,
  localparam int unsigned AVAIL_W   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_PORTS-1:0]        valid_i,
  input  fifo_t [N_PORTS-1:0]       element_i,
  output logic [N_PORTS-1:0]        ready_o,
  input  logic [AVAIL_W-1:0]        avail_i,
  output logic [N_PORTS-1:0]        push_o,
  output fifo_t [N_PORTS-1:0]       element_o,
  output logic                      stall_o
);
  // Port index width (1 bit minimum) and budget arithmetic width. The budget
  // math is one bit wider than the larger of avail_i and the push count so
  // that the subtraction never wraps before saturation.
  localparam int unsigned IW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(N_PORTS + 1);
  localparam int unsigned BW    = ((AVAIL_W > CNT_W) ? AVAIL_W : CNT_W) + 1;

  if (N_PORTS == 0) begin : g_bad_ports
    $fatal(1, "fractal_sync_mp_admit: N_PORTS must be > 0");
  end
  if (FIFO_DEPTH == 0) begin : g_bad_depth
    $fatal(1, "fractal_sync_mp_admit: FIFO_DEPTH must be > 0");
  end

  logic [BW-1:0]      pushed_n, budget, granted_n;
  logic [N_PORTS-1:0] grant;
  logic [IW-1:0]      start;
  logic [IW:0]        pos;
  logic               stall_q, stall_d;

  // In-flight pushes are not yet reflected in avail_i, so they are charged
  // against the budget here.
  always_comb begin
    pushed_n = '0;
    for (int i = 0; i < N_PORTS; i++) pushed_n = pushed_n + BW'(push_o[i]);
    budget = (BW'(avail_i) > pushed_n) ? BW'(avail_i) - pushed_n : '0;
  end

`ifdef FRACTAL_SYNC_MP_ADMIT_RR_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, last_idx;
  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  // Scan from start, wrapping, granting valid ports until the budget is used.
  always_comb begin
    grant     = '0;
    granted_n = '0;
    pos       = '0;
`ifdef FRACTAL_SYNC_MP_ADMIT_RR_EN
    last_idx  = '0;
`endif
    for (int k = 0; k < N_PORTS; k++) begin
      pos = {1'b0, start} + (IW+1)'(k);
      if (pos >= (IW+1)'(N_PORTS)) pos = pos - (IW+1)'(N_PORTS);
      if (valid_i[pos[IW-1:0]] && (granted_n < budget)) begin
        grant[pos[IW-1:0]] = 1'b1;
        granted_n          = granted_n + BW'(1);
`ifdef FRACTAL_SYNC_MP_ADMIT_RR_EN
        last_idx           = pos[IW-1:0];
`endif
      end
    end
  end

  // Nothing is accepted while reset is asserted.
  assign ready_o = grant & {N_PORTS{rst_ni}};
  assign stall_d = |(valid_i & ~ready_o);

`ifdef FRACTAL_SYNC_MP_ADMIT_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|ready_o)
      rr_ptr_d = (last_idx == IW'(N_PORTS - 1)) ? '0 : last_idx + IW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= 1'b0;
    else         stall_q <= stall_d;
  end
  assign stall_o = stall_q;

  // Lanes register in port order, so the FIFO sees lowest index first no
  // matter where the grant scan started.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_lane
    fractal_sync_mp_admit_lane #(.fifo_t(fifo_t)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .acc_i  (ready_o[g]),
      .elem_i (element_i[g]),
      .push_o (push_o[g]),
      .elem_o (element_o[g])
    );
  end
endmodule

// File: tb/tb_fractal_sync_mp_admit.sv
module tb_fractal_sync_mp_admit;
  typedef logic [7:0] byte_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      valid;
  logic [3:0][7:0] elem;
  logic [3:0]      ready;
  logic [3:0]      avail;
  logic [3:0]      push;
  logic [3:0][7:0] eo;
  logic            stall;

  // Second instance: two ports in front of a depth-1 FIFO model.
  logic [1:0] valid2, ready2, push2, elem2, eo2;
  logic       avail2, stall2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fractal_sync_mp_admit #(.N_PORTS(4), .FIFO_DEPTH(8), .fifo_t(byte_t)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .element_i(elem),
    .ready_o(ready), .avail_i(avail), .push_o(push), .element_o(eo),
    .stall_o(stall)
  );

  fractal_sync_mp_admit #(.N_PORTS(2), .FIFO_DEPTH(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid2), .element_i(elem2),
    .ready_o(ready2), .avail_i(avail2), .push_o(push2), .element_o(eo2),
    .stall_o(stall2)
  );

  // Depth-1 FIFO model: consumer pops every cycle the FIFO holds an entry.
  int cnt2, ovf2, pair2, total2;
  logic prev2;
  assign avail2 = (cnt2 == 0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt2 <= 0; ovf2 <= 0; pair2 <= 0; total2 <= 0; prev2 <= 1'b0;
    end else begin
      cnt2   <= cnt2 - int'(cnt2 > 0) + int'(push2[0]) + int'(push2[1]);
      if (cnt2 - int'(cnt2 > 0) + int'(push2[0]) + int'(push2[1]) > 1) ovf2 <= ovf2 + 1;
      if ((|push2 && prev2) || (&push2)) pair2 <= pair2 + 1;
      total2 <= total2 + int'(push2[0]) + int'(push2[1]);
      prev2  <= |push2;
    end
  end

  typedef struct {
    logic [3:0]      avail;
    logic [3:0]      valid;
    logic [3:0][7:0] elem;
    logic [3:0]      ready;  // combinational, this cycle
    logic [3:0]      push;   // after the edge
    logic [3:0][7:0] eo;     // after the edge
    logic            stall;  // after the edge
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(logic [3:0] a, logic [3:0] v, logic [31:0] e,
                              logic [3:0] r, logic [3:0] p, logic [31:0] o,
                              logic s);
    vec_t t;
    t.avail = a; t.valid = v; t.elem = e; t.ready = r;
    t.push = p; t.eo = o; t.stall = s;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [3:0] seq_rdy[5];

  initial begin
    valid = '0; elem = '0; avail = '0; valid2 = '0; elem2 = 2'b10;

    // Every row's expectations follow from the previous row's grants.
    tbl[0] = mk(4'd8, 4'hF, 32'h0D0C0B0A, 4'hF, 4'hF, 32'h0D0C0B0A, 1'b0);
    tbl[1] = mk(4'd2, 4'hF, 32'h14131211, 4'h0, 4'h0, 32'h0D0C0B0A, 1'b1); // stale avail: 2-4 -> 0
    tbl[2] = mk(4'd2, 4'hF, 32'h14131211, 4'h3, 4'h3, 32'h0D0C1211, 1'b1);
    tbl[3] = mk(4'd2, 4'hF, 32'h14131211, 4'h0, 4'h0, 32'h0D0C1211, 1'b1); // 2-2 -> 0
    tbl[4] = mk(4'd2, 4'hC, 32'h24232221, 4'hC, 4'hC, 32'h24231211, 1'b0);
    tbl[5] = mk(4'd0, 4'h0, 32'h00000000, 4'h0, 4'h0, 32'h24231211, 1'b0);
    tbl[6] = mk(4'd1, 4'hA, 32'h34333231, 4'h2, 4'h2, 32'h24233211, 1'b1);
    tbl[7] = mk(4'd3, 4'h5, 32'h44434241, 4'h5, 4'h5, 32'h24433241, 1'b0);

    // Reset state
    #3;
    valid = 4'hF; avail = 4'd8;
    #1;
    chk("reset ready", 64'(ready), 64'h0);
    chk("reset push", 64'(push), 64'h0);
    chk("reset eo", 64'(eo), 64'h0);
    chk("reset stall", 64'(stall), 64'h0);
    valid = '0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      avail = tbl[i].avail; valid = tbl[i].valid; elem = tbl[i].elem;
      #2;
      chk($sformatf("row%0d ready", i), 64'(ready), 64'(tbl[i].ready));
      @(posedge clk); #1;
      chk($sformatf("row%0d push", i), 64'(push), 64'(tbl[i].push));
      chk($sformatf("row%0d eo", i), 64'(eo), 64'(tbl[i].eo));
      chk($sformatf("row%0d stall", i), 64'(stall), 64'(tbl[i].stall));
    end

    // Reset right after a grant drops the pending push.
    @(negedge clk);
    avail = 4'd8; valid = 4'hF; elem = 32'h55545352;
    @(posedge clk); #1;
    chk("rst pre push", 64'(push), 64'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst push", 64'(push), 64'h0);
    chk("rst stall", 64'(stall), 64'h0);
    chk("rst eo", 64'(eo), 64'h0);
    chk("rst ready", 64'(ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; valid = '0;
    @(posedge clk); #1;
    chk("rst no replay", 64'(push), 64'h0);

    // Budget 2 with all ports valid; round-robin vs fixed priority.
`ifdef FRACTAL_SYNC_MP_ADMIT_RR_EN
    seq_rdy = '{4'h3, 4'h0, 4'hC, 4'h0, 4'h3};
`else
    seq_rdy = '{4'h3, 4'h0, 4'h3, 4'h0, 4'h3};
`endif
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      avail = 4'd2; valid = 4'hF; elem = 32'h64636261;
      #2;
      chk($sformatf("seq%0d ready", s), 64'(ready), 64'(seq_rdy[s]));
      @(posedge clk); #1;
      chk($sformatf("seq%0d push", s), 64'(push), 64'(seq_rdy[s]));
      chk($sformatf("seq%0d stall", s), 64'(stall), 64'(1));
    end
    @(negedge clk); valid = '0;

    // Depth-1 FIFO fed by two always-valid ports.
    valid2 = 2'b11;
    repeat (40) @(posedge clk);
    #1;
    chk("fifo overflow", 64'(ovf2), 64'h0);
    chk("fifo push spacing", 64'(pair2), 64'h0);
    chk("fifo progress", 64'(total2 >= 10), 64'h1);
    valid2 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
